sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//  - Single-clock synchronous FIFO, parametrised in data width and depth. Successor to the fixed 8x16 buffer.
//  - Adds simultaneous push/pop, occupancy count, programmable almost-full/almost-empty and overflow/underflow pulses.
//  - Generic elastic buffer between producer/consumer stages inside one clock domain; optional first-word-fall-through read mode.
// PARAMETERS
//  - WIDTH     8    data word width in bits (>=1)
//  - DEPTH     16   number of entries; power of 2, >=2; AW = $clog2(DEPTH)
//  - AF_LEVEL  14   almost_full asserted when count >= AF_LEVEL (1..DEPTH)
//  - AE_LEVEL  2    almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
// PORTS
//  - clk           in   1      clock, all logic on rising edge
//  - rst           in   1      synchronous reset, active-high
//  - wr            in   1      push request
//  - din           in   WIDTH  push data
//  - rd            in   1      pop request (FWFT mode: acknowledge of head word)
//  - dout          out  WIDTH  read data
//  - full          out  1      count == DEPTH
//  - empty         out  1      count == 0
//  - almost_full   out  1      count >= AF_LEVEL
//  - almost_empty  out  1      count <= AE_LEVEL
//  - count         out  AW+1   current occupancy, 0..DEPTH
//  - overflow      out  1      1-cycle pulse: wr while full and no push accepted
//  - underflow     out  1      1-cycle pulse: rd while empty
// BEHAVIOUR
//  - Reset: wptr=rptr=0, count=0, dout=0, overflow=underflow=0.
//    empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0). Memory array is not cleared.
//    rd/wr in a reset cycle are ignored. Reset mid-operation discards all stored words.
//  - push = wr && !full; pop = rd && !empty. Both are evaluated on the pre-edge count and are independent of each other.
//    - push: mem[wptr]<=din, wptr+1.
//    - pop: rptr+1.
//    - count += push - pop. push&&pop leaves count unchanged.
//  - Full with rd&wr: pop accepted, push rejected, overflow=1 (no write-through).
//  - Empty with rd&wr: push accepted, pop rejected, underflow=1.
//  - Pointers are AW bits and wrap DEPTH-1 -> 0 naturally. full/empty are decoded from count, never from pointer compare.
//  - All flags are combinational decodes of the registered count. A push is visible on the flags/count the cycle after the accepting edge.
//  - overflow/underflow are registered; high exactly the cycle after the offending edge.
// CONFIGURATION
//  - Macro FIFO_FWFT_EN.
//  - Undefined (standard mode): dout registered; on pop, dout<=mem[rptr], valid the cycle after the rd edge. Otherwise dout holds.
//  - Defined (first-word-fall-through): dout = mem[rptr] whenever !empty (0 when empty). Head word is visible the cycle after its
//    push into an empty FIFO. rd consumes the shown word. Flags, count and pulses are identical in both modes.
// STRUCTURE
//  - Package fifo_pkg: function clog2-based AW helper, localparam-free typedef of count width via parameterised struct not used.
//    Holds the shared constants FIFO_DEF_WIDTH=8 and FIFO_DEF_DEPTH=16.
//  - Sub-module fifo_ram: DEPTH x WIDTH memory, 1 sync write port, 1 async read port (the read address is rptr).
//  - The top holds pointers, count, flags, dout register and mode mux.
//  - Elaboration check: DEPTH is a power of 2 and the AF/AE levels are in range, else $fatal.
// TESTING (WIDTH=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2)
//  - Reset: assert rst 2 cycles -> empty=1, full=0, count=0, dout=0, almost_empty=1, almost_full=0.
//  - Fill: push 0x00..0x0F -> almost_full rises after the 14th push, full=1 and count=16 after the 16th.
//    A 17th wr (0xAA) -> overflow pulse 1 cycle, count stays 16, 0xAA never read.
//  - Drain: 16 pops -> dout sequence 0x00..0x0F in order. almost_empty rises at count=2, empty=1 at the end.
//    An extra rd -> underflow pulse, dout holds 0x0F (std mode).
//  - Wrap + concurrency: preload 8 words, then 40 cycles of rd&wr with incrementing data -> count stays 8, order preserved across
//    pointer wrap, no pulses.
//  - Boundary simultaneity: at full, rd&wr -> count 15, overflow=1. At empty, rd&wr with din=0x5C -> count 1, underflow=1,
//    next pop returns 0x5C.
//  - Mid-op reset: at count=9, assert rst with wr=1 -> count=0, empty=1, the reset-cycle din is not stored.
//    With FIFO_FWFT_EN: push 0x33 into empty -> dout=0x33 next cycle with no rd.

Source files
------------

// File: rtl/sync_fifo_param_pkg.sv
// Shared constants and sizing helpers for the parametrised synchronous FIFO.
package fifo_pkg;

  localparam int FIFO_DEF_WIDTH = 8;
  localparam int FIFO_DEF_DEPTH = 16;

  function automatic int fifo_aw(input int depth);
    return $clog2(depth);
  endfunction

  function automatic bit fifo_is_pow2(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// FIFO producer/consumer bundle; master drives wr/din/rd, slave is the FIFO itself.
interface sync_fifo_param_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_DEF_WIDTH,
  parameter int DEPTH = FIFO_DEF_DEPTH
);

  logic                     wr;
  logic [WIDTH-1:0]         din;
  logic                     rd;
  logic [WIDTH-1:0]         dout;
  logic                     full;
  logic                     empty;
  logic                     almost_full;
  logic                     almost_empty;
  logic [fifo_aw(DEPTH):0]  count;
  logic                     overflow;
  logic                     underflow;

  modport master (
    output wr, din, rd,
    input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr, din, rd,
    output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_param_ram.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO: registered dout one cycle after pop, or fall-through head when FIFO_FWFT_EN is defined.
// Flags decode the registered count; rejected pushes/pops raise a one-cycle overflow/underflow pulse.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = FIFO_DEF_WIDTH,
  parameter int DEPTH    = FIFO_DEF_DEPTH,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input logic              clk,
  input logic              rst,
  sync_fifo_param_if.slave bus
);

  localparam int AW = fifo_aw(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C   = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_C   = (AW+1)'(AE_LEVEL);

  if (!fifo_is_pow2(DEPTH)) begin : g_bad_depth
    $fatal(1, "sync_fifo_param: DEPTH must be a power of 2 and >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $fatal(1, "sync_fifo_param: AF_LEVEL out of range 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $fatal(1, "sync_fifo_param: AE_LEVEL out of range 0..DEPTH-1");
  end

  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      cnt;
  logic [WIDTH-1:0] rdata;
  logic             full_w;
  logic             empty_w;
  logic             push;
  logic             pop;
  logic             ovf_q;
  logic             udf_q;

  // Occupancy alone decides full/empty, so equal pointers are never ambiguous.
  assign full_w  = (cnt == FULL_C);
  assign empty_w = (cnt == '0);
  assign push    = bus.wr && !full_w;
  assign pop     = bus.rd && !empty_w;

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push && !rst),
    .waddr (wptr),
    .wdata (bus.din),
    .raddr (rptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      ovf_q <= bus.wr && full_w;
      udf_q <= bus.rd && empty_w;
    end
  end

`ifdef FIFO_FWFT_EN
  assign bus.dout = empty_w ? '0 : rdata;
`else
  logic [WIDTH-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (rst)      dout_q <= '0;
    else if (pop) dout_q <= rdata;
  end

  assign bus.dout = dout_q;
`endif

  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (cnt >= AF_C);
  assign bus.almost_empty = (cnt <= AE_C);
  assign bus.count        = cnt;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed plus random stimulus for sync_fifo_param, checked every cycle against a queue-based occupancy model.
module tb_sync_fifo_param;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AF = 14;
  localparam int AE = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  logic [W-1:0] model[$];
  logic [W-1:0] exp_dout = '0;
  logic         exp_ovf  = 1'b0;
  logic         exp_udf  = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_param_if #(.WIDTH(W), .DEPTH(D)) bus ();

  sync_fifo_param #(
    .WIDTH    (W),
    .DEPTH    (D),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One clock: apply inputs, let the edge happen, advance the model, compare every output.
  task automatic cycle(input string tag, input logic r, input logic w, input logic rd_i, input logic [W-1:0] d);
    int           pre;
    logic [W-1:0] head;
    rst    = r;
    bus.wr = w;
    bus.rd = rd_i;
    bus.din = d;
    @(posedge clk);
    #1;
    pre = model.size();
    if (r) begin
      model.delete();
      exp_dout = '0;
      exp_ovf  = 1'b0;
      exp_udf  = 1'b0;
    end else begin
      exp_ovf = w && (pre == D);
      exp_udf = rd_i && (pre == 0);
      if (rd_i && pre > 0) begin
        head = model.pop_front();
`ifndef FIFO_FWFT_EN
        exp_dout = head;
`endif
      end
      if (w && pre < D) model.push_back(d);
    end
`ifdef FIFO_FWFT_EN
    exp_dout = (model.size() > 0) ? model[0] : '0;
`endif
    check({tag, ".count"},        bus.count,        model.size());
    check({tag, ".full"},         bus.full,         model.size() == D);
    check({tag, ".empty"},        bus.empty,        model.size() == 0);
    check({tag, ".almost_full"},  bus.almost_full,  model.size() >= AF);
    check({tag, ".almost_empty"}, bus.almost_empty, model.size() <= AE);
    check({tag, ".overflow"},     bus.overflow,     exp_ovf);
    check({tag, ".underflow"},    bus.underflow,    exp_udf);
    check({tag, ".dout"},         bus.dout,         exp_dout);
  endtask

  initial begin
    bus.wr  = 1'b0;
    bus.rd  = 1'b0;
    bus.din = '0;

    // Reset held for two cycles.
    cycle("reset0", 1'b1, 1'b0, 1'b0, 8'h00);
    cycle("reset1", 1'b1, 1'b0, 1'b0, 8'h00);
    check("reset.count_zero", bus.count, 32'd0);
    check("reset.dout_zero",  bus.dout,  32'd0);

    // Fill to full, then one rejected push.
    for (int i = 0; i < D; i++) cycle("fill", 1'b0, 1'b1, 1'b0, W'(i));
    check("fill.full_flag", bus.full, 32'd1);
    cycle("push17", 1'b0, 1'b1, 1'b0, 8'hAA);
    check("push17.overflow", bus.overflow, 32'd1);
    cycle("post17", 1'b0, 1'b0, 1'b0, 8'h00);
    check("post17.pulse_gone", bus.overflow, 32'd0);

    // Drain in order, then one rejected pop.
    for (int i = 0; i < D; i++) cycle("drain", 1'b0, 1'b0, 1'b1, 8'h00);
    check("drain.empty_flag", bus.empty, 32'd1);
    cycle("extra_rd", 1'b0, 1'b0, 1'b1, 8'h00);
    check("extra_rd.underflow", bus.underflow, 32'd1);
    cycle("post_udf", 1'b0, 1'b0, 1'b0, 8'h00);

    // Preload 8 words, then steady rd&wr across pointer wrap.
    for (int i = 0; i < 8; i++) cycle("preload", 1'b0, 1'b1, 1'b0, W'(8'h40 + i));
    for (int i = 0; i < 40; i++) cycle("wrap", 1'b0, 1'b1, 1'b1, W'(8'h80 + i));
    check("wrap.count_eight", bus.count, 32'd8);
    for (int i = 0; i < 8; i++) cycle("wrap_drain", 1'b0, 1'b0, 1'b1, 8'h00);

    // Simultaneous rd&wr at the full and empty boundaries.
    for (int i = 0; i < D; i++) cycle("refill", 1'b0, 1'b1, 1'b0, W'(8'hC0 + i));
    cycle("full_rdwr", 1'b0, 1'b1, 1'b1, 8'hEE);
    check("full_rdwr.count15", bus.count, 32'd15);
    for (int i = 0; i < D - 1; i++) cycle("drain2", 1'b0, 1'b0, 1'b1, 8'h00);
    cycle("empty_rdwr", 1'b0, 1'b1, 1'b1, 8'h5C);
    check("empty_rdwr.count1", bus.count, 32'd1);
    cycle("pop_5c", 1'b0, 1'b0, 1'b1, 8'h00);
`ifndef FIFO_FWFT_EN
    check("pop_5c.value", bus.dout, 32'h5C);
`endif

    // Reset in the middle of traffic with a push pending.
    for (int i = 0; i < 9; i++) cycle("load9", 1'b0, 1'b1, 1'b0, W'(8'h10 + i));
    cycle("midrst", 1'b1, 1'b1, 1'b0, 8'h77);
    check("midrst.empty", bus.empty, 32'd1);
    cycle("after_rst_push", 1'b0, 1'b1, 1'b0, 8'h33);
`ifdef FIFO_FWFT_EN
    check("fwft.head_visible", bus.dout, 32'h33);
`endif
    cycle("after_rst_pop", 1'b0, 1'b0, 1'b1, 8'h00);
`ifndef FIFO_FWFT_EN
    check("midrst.not_stored", bus.dout, 32'h33);
`endif

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      cycle("rand", ($urandom_range(63) == 0), ($urandom_range(99) < 55),
            ($urandom_range(99) < 50), W'($urandom));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
